// File: rtl/fft_in_framer.sv
// Serial-to-parallel framer in front of an FFT. It collects N serial complex samples
// in a ping-pong buffer and replays each full frame as N/LANES parallel beats.
// Latency: when the last sample is accepted at edge E, beat 0 is registered at edge E+1.
// Backpressure: in_ready drops while the write bank is still full. The output side has no ready input.
//
// Ports:
//   clk, rstn                      single rising-edge clock and async active-low reset
//   in_valid/in_ready/in_i/in_q    serial sample handshake; in_last ends a frame early (discard)
//   in_last
//   dout_valid, dout_i[], dout_q[] registered parallel beat; data holds while dout_valid is low
//   frame_start                    high together with beat 0 of each frame
//   frame_err                      one-cycle pulse after a short frame is discarded
module fft_in_framer #(
   parameter int N     = 512,
   parameter int LANES = 16
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [12:0] in_i,
   input  logic signed [12:0] in_q,
   input  logic               in_last,
   output logic               dout_valid,
   output logic signed [12:0] dout_i [0:LANES-1],
   output logic signed [12:0] dout_q [0:LANES-1],
   output logic               frame_start,
   output logic               frame_err
);

   localparam int BPF = N / LANES;
   localparam int CW  = (N > 1) ? $clog2(N) : 1;
   localparam int BW  = (BPF > 1) ? $clog2(BPF) : 1;
   localparam logic [CW-1:0] LAST_CNT  = CW'(N - 1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BPF - 1);

   typedef enum logic {IDLE, BURST} state_t;

   logic signed [12:0] mem_i [0:1][0:N-1];
   logic signed [12:0] mem_q [0:1][0:N-1];

   state_t          state, state_n;
   logic            wr_bank, wr_bank_n;
   logic            rd_bank, rd_bank_n;
   logic [1:0]      full, full_n;
   logic [CW-1:0]   wr_cnt, wr_cnt_n;
   logic [BW-1:0]   beat, beat_n, ld_beat;
   logic            acc, err_n, rdy_n;
   logic            ld, ld_bank, fs_n, vld_n, end_burst;
   logic signed [12:0] rd_i [0:LANES-1];
   logic signed [12:0] rd_q [0:LANES-1];

   assign acc = in_valid & in_ready;

   // Read FSM. "beat" is the index of the beat currently on the outputs.
   // A new beat is loaded into the output registers on every BURST edge.
   always_comb begin
      state_n   = state;
      rd_bank_n = rd_bank;
      beat_n    = beat;
      ld        = 1'b0;
      ld_bank   = rd_bank;
      ld_beat   = '0;
      fs_n      = 1'b0;
      vld_n     = 1'b0;
      end_burst = 1'b0;
      case (state)
         IDLE: begin
            if (full[rd_bank]) begin
               ld      = 1'b1;
               beat_n  = '0;
               fs_n    = 1'b1;
               vld_n   = 1'b1;
               state_n = BURST;
            end
         end
         BURST: begin
            if (beat == LAST_BEAT) begin
               // This edge retires the last beat. If the other bank is already
               // full, chain straight into it so there is no idle cycle.
               end_burst = 1'b1;
               rd_bank_n = ~rd_bank;
               if (full[~rd_bank]) begin
                  ld      = 1'b1;
                  ld_bank = ~rd_bank;
                  beat_n  = '0;
                  fs_n    = 1'b1;
                  vld_n   = 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               ld      = 1'b1;
               ld_beat = beat + 1'b1;
               beat_n  = beat + 1'b1;
               vld_n   = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Write side and full flags. The reader only ever clears the bank it is
   // draining, and the writer only ever sets a bank that is not full, so the
   // set and the clear can land on the same edge without conflict.
   always_comb begin
      full_n    = full;
      wr_bank_n = wr_bank;
      wr_cnt_n  = wr_cnt;
      err_n     = 1'b0;
      if (end_burst) full_n[rd_bank] = 1'b0;
      if (acc) begin
         if (wr_cnt == LAST_CNT) begin
            full_n[wr_bank] = 1'b1;
            wr_bank_n       = ~wr_bank;
            wr_cnt_n        = '0;
         end else if (in_last) begin
            wr_cnt_n = '0;
            err_n    = 1'b1;
         end else begin
            wr_cnt_n = wr_cnt + 1'b1;
         end
      end
      rdy_n = ~full_n[wr_bank_n];
   end

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         rd_i[l] = mem_i[ld_bank][CW'(int'(ld_beat) * LANES + l)];
         rd_q[l] = mem_q[ld_bank][CW'(int'(ld_beat) * LANES + l)];
      end
   end

   // Sample storage is not reset.
   always_ff @(posedge clk) begin
      if (acc) begin
         mem_i[wr_bank][wr_cnt] <= in_i;
         mem_q[wr_bank][wr_cnt] <= in_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         full        <= '0;
         wr_cnt      <= '0;
         beat        <= '0;
         in_ready    <= 1'b1;
         dout_valid  <= 1'b0;
         frame_start <= 1'b0;
         frame_err   <= 1'b0;
         for (int l = 0; l < LANES; l++) begin
            dout_i[l] <= '0;
            dout_q[l] <= '0;
         end
      end else begin
         state       <= state_n;
         wr_bank     <= wr_bank_n;
         rd_bank     <= rd_bank_n;
         full        <= full_n;
         wr_cnt      <= wr_cnt_n;
         beat        <= beat_n;
         in_ready    <= rdy_n;
         dout_valid  <= vld_n;
         frame_start <= fs_n;
         frame_err   <= err_n;
         if (ld) begin
            for (int l = 0; l < LANES; l++) begin
               dout_i[l] <= rd_i[l];
               dout_q[l] <= rd_q[l];
            end
         end
      end
   end

endmodule

// File: tb/tb_fft_in_framer.sv
module tb_fft_in_framer;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   // default instance: N=512, LANES=16
   logic in_valid, in_ready, in_last, dout_valid, frame_start, frame_err;
   logic signed [12:0] in_i, in_q;
   logic signed [12:0] dout_i [0:15];
   logic signed [12:0] dout_q [0:15];

   // small instance: N=32, LANES=1 (32-beat burst, same length as a frame)
   logic s_in_valid, s_in_ready, s_in_last, s_dout_valid, s_frame_start, s_frame_err;
   logic signed [12:0] s_in_i, s_in_q;
   logic signed [12:0] s_dout_i [0:0];
   logic signed [12:0] s_dout_q [0:0];

   fft_in_framer dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .in_i(in_i), .in_q(in_q), .in_last(in_last), .dout_valid(dout_valid),
      .dout_i(dout_i), .dout_q(dout_q), .frame_start(frame_start), .frame_err(frame_err));

   fft_in_framer #(.N(32), .LANES(1)) dut_s (
      .clk(clk), .rstn(rstn), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_i(s_in_i), .in_q(s_in_q), .in_last(s_in_last), .dout_valid(s_dout_valid),
      .dout_i(s_dout_i), .dout_q(s_dout_q), .frame_start(s_frame_start), .frame_err(s_frame_err));

   typedef struct packed {
      logic [16*13-1:0] i;
      logic [16*13-1:0] q;
      logic             fs;
   } beat_t;

   beat_t qb[$];
   beat_t qs[$];

   int total = 0;
   int pass  = 0;
   int cyc   = 0;
   int last_e = 0;
   int b_idx = 0;
   int err_cnt = 0, err_wide = 0, rdy_low = 0;
   int s_run = 0, s_max_run = 0;
   bit prev_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input bit ok, input longint act, input longint exp);
      total++;
      if (ok) pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic signed [12:0] samp(input int pat, input int n, input bit q);
      int vi, vq;
      case (pat)
         0: begin vi = n;         vq = -n;        end
         1: begin vi = 2000 - n;  vq = n - 2000;  end
         2: begin
            if (n % 3 == 0)      begin vi = 4095;  vq = -4096; end
            else if (n % 3 == 1) begin vi = -4096; vq = 4095;  end
            else                 begin vi = n;     vq = -n - 1; end
         end
         3: begin vi = 100 + n;   vq = -200 - n;  end
         default: begin vi = -300 - n; vq = 400 + n; end
      endcase
      return q ? 13'(vq) : 13'(vi);
   endfunction

   // Drive one frame; push its expected beats when all samples were accepted
   // and the frame is full length.
   task automatic send_frame(input bit sm, input int len, input int pat, input bit gaps,
                             input bit last_flag);
      logic signed [12:0] vi[$];
      logic signed [12:0] vq[$];
      int n = 0, guard = 0, lanes;
      bit v, rdy;
      beat_t e;
      while (n < len) begin
         v = gaps ? 1'($urandom_range(1)) : 1'b1;
         if (sm) begin
            s_in_valid = v; s_in_i = samp(pat, n, 0); s_in_q = samp(pat, n, 1);
            s_in_last = last_flag && (n == len - 1);
            rdy = s_in_ready;
         end else begin
            in_valid = v; in_i = v ? samp(pat, n, 0) : 13'sh0AA; in_q = v ? samp(pat, n, 1) : 13'sh155;
            in_last = last_flag && (n == len - 1);
            rdy = in_ready;
         end
         @(posedge clk); #1;
         if (v && rdy) begin
            vi.push_back(samp(pat, n, 0));
            vq.push_back(samp(pat, n, 1));
            n++;
         end
         guard++;
         if (guard > len * 10 + 500) begin
            check("send_timeout", 1'b0, n, len);
            break;
         end
      end
      last_e = cyc;
      if (sm) begin s_in_valid = 1'b0; s_in_last = 1'b0; end
      else    begin in_valid = 1'b0;   in_last = 1'b0;   end
      lanes = sm ? 1 : 16;
      if (n == len && len == (sm ? 32 : 512)) begin
         for (int k = 0; k < 32; k++) begin
            e = '0;
            e.fs = (k == 0);
            for (int l = 0; l < lanes; l++) begin
               e.i[l*13 +: 13] = vi[k*lanes + l];
               e.q[l*13 +: 13] = vq[k*lanes + l];
            end
            if (sm) qs.push_back(e); else qb.push_back(e);
         end
      end
   endtask

   task automatic drain();
      int w = 0;
      while ((qb.size() != 0 || qs.size() != 0) && w < 300) begin
         @(negedge clk);
         w++;
      end
      repeat (3) @(negedge clk);
      check("drain", qb.size() + qs.size() == 0, qb.size() + qs.size(), 0);
   endtask

   // Monitor: default instance
   always @(negedge clk) begin
      beat_t e;
      bit ok;
      int bl;
      if (frame_err) begin
         err_cnt++;
         if (prev_err) err_wide++;
      end
      prev_err = frame_err;
      if (rstn && !in_ready) rdy_low++;
      if (!rstn) b_idx = 0;
      if (dout_valid) begin
         b_idx = frame_start ? 0 : b_idx + 1;
         if (qb.size() == 0) begin
            check("unexpected_beat", 1'b0, b_idx, -1);
         end else begin
            e = qb.pop_front();
            check("beat_frame_start", frame_start == e.fs, frame_start, e.fs);
            ok = 1'b1; bl = 0;
            for (int l = 0; l < 16; l++) begin
               if (ok && (dout_i[l] !== e.i[l*13 +: 13] || dout_q[l] !== e.q[l*13 +: 13])) begin
                  ok = 1'b0; bl = l;
               end
            end
            if (!ok) $display("FAIL beat_lane%0d beat%0d: got I=%0d Q=%0d expected I=%0d Q=%0d",
                              bl, b_idx, dout_i[bl], dout_q[bl],
                              $signed(e.i[bl*13 +: 13]), $signed(e.q[bl*13 +: 13]));
            total++;
            if (ok) pass++;
         end
      end
   end

   // Monitor: small instance
   always @(negedge clk) begin
      beat_t e;
      if (s_dout_valid) begin
         s_run++;
         if (s_run > s_max_run) s_max_run = s_run;
         if (qs.size() == 0) begin
            check("s_unexpected_beat", 1'b0, s_dout_i[0], -1);
         end else begin
            e = qs.pop_front();
            check("s_beat_frame_start", s_frame_start == e.fs, s_frame_start, e.fs);
            check("s_beat_i", s_dout_i[0] === e.i[12:0], s_dout_i[0], $signed(e.i[12:0]));
            check("s_beat_q", s_dout_q[0] === e.q[12:0], s_dout_q[0], $signed(e.q[12:0]));
         end
      end else begin
         s_run = 0;
      end
   end

   initial begin
      int w, e0, any;
      rstn = 1'b0;
      in_valid = 0; in_last = 0; in_i = 0; in_q = 0;
      s_in_valid = 0; s_in_last = 0; s_in_i = 0; s_in_q = 0;
      repeat (3) @(negedge clk);
      check("rst_dout_valid", dout_valid == 1'b0, dout_valid, 0);
      check("rst_frame_start", frame_start == 1'b0, frame_start, 0);
      check("rst_frame_err", frame_err == 1'b0, frame_err, 0);
      any = 0;
      for (int l = 0; l < 16; l++) if (dout_i[l] != 0 || dout_q[l] != 0) any++;
      check("rst_lanes_zero", any == 0, any, 0);
      rstn = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready == 1'b1, in_ready, 1);

      // single ramp frame and latency
      send_frame(0, 512, 0, 0, 1);
      w = 0;
      while (!dout_valid && w < 20) begin @(negedge clk); w++; end
      check("latency_edges", cyc - last_e == 1, cyc - last_e, 1);
      drain();

      // two back-to-back frames, continuous input
      rdy_low = 0;
      send_frame(0, 512, 1, 0, 1);
      send_frame(0, 512, 0, 0, 1);
      drain();
      check("b2b_in_ready_low", rdy_low == 0, rdy_low, 0);

      // short frame (in_last at sample 99) then a full frame
      e0 = err_cnt; err_wide = 0;
      send_frame(0, 100, 0, 0, 1);
      send_frame(0, 512, 1, 0, 1);
      drain();
      check("short_err_pulses", err_cnt - e0 == 1, err_cnt - e0, 1);
      check("short_err_width", err_wide == 0, err_wide, 0);

      // reset mid-burst at beat 10
      send_frame(0, 512, 0, 0, 1);
      w = 0;
      do begin @(negedge clk); #1; w++; end while (!(dout_valid && b_idx == 10) && w < 100);
      check("reach_beat10", b_idx == 10, b_idx, 10);
      rstn = 1'b0;
      #1;
      qb.delete();
      check("mid_rst_valid", dout_valid == 1'b0, dout_valid, 0);
      check("mid_rst_fs", frame_start == 1'b0, frame_start, 0);
      any = 0;
      for (int l = 0; l < 16; l++) if (dout_i[l] != 0 || dout_q[l] != 0) any++;
      check("mid_rst_lanes", any == 0, any, 0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      check("mid_rst_in_ready", in_ready == 1'b1, in_ready, 1);
      send_frame(0, 512, 2, 0, 1);
      drain();

      // 50% valid gaps, extreme values, in_last low on the final sample
      send_frame(0, 512, 2, 1, 0);
      drain();

      // small instance: both banks full, second burst chains without a gap
      s_max_run = 0;
      send_frame(1, 32, 3, 0, 1);
      send_frame(1, 32, 4, 0, 1);
      check("s_ready_low_both_full", s_in_ready == 1'b0, s_in_ready, 0);
      @(posedge clk); #1;
      check("s_ready_back_after_burst", s_in_ready == 1'b1, s_in_ready, 1);
      drain();
      check("s_no_gap_run", s_max_run == 64, s_max_run, 64);

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
